// File: rtl/cabac_rate_est_pipe.sv
// Three-stage pipelined CABAC fractional-bit rate estimator for NUM_CAND candidate levels.
// Optional performance counters are compiled in with CABAC_RATE_PERF_EN.
module cabac_rate_est_pipe #(
    parameter int NUM_CAND  = 3,
    parameter int LEVEL_W   = 16,
    parameter int RATE_W    = 32,
    parameter int FRAC_BITS = 15,
    parameter int TAG_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [TAG_W-1:0]            in_tag,
    input  logic [NUM_CAND*LEVEL_W-1:0] cand_level,
    input  logic [7:0]                  c1_idx,
    input  logic [7:0]                  c2_idx,
    input  logic [15:0]                 gt1_cost0,
    input  logic [15:0]                 gt1_cost1,
    input  logic [15:0]                 abs_cost0,
    input  logic [15:0]                 abs_cost1,
    input  logic [2:0]                  rice_param,
    input  logic                        use_limited_prefix,
    input  logic [4:0]                  max_log2_tr_range,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [TAG_W-1:0]            out_tag,
    output logic [NUM_CAND*RATE_W-1:0]  out_rate
`ifdef CABAC_RATE_PERF_EN
    ,
    output logic [31:0]                 perf_req_cnt,
    output logic [31:0]                 perf_stall_cnt,
    output logic [31:0]                 perf_escape_cnt
`endif
);

    // Wide enough that U + bits*U + costs can never wrap before saturation.
    localparam int WIDE_W = RATE_W + FRAC_BITS + 8;

    localparam logic [1:0] CLS_ZERO  = 2'd0;
    localparam logic [1:0] CLS_ONE   = 2'd1;
    localparam logic [1:0] CLS_TWO   = 2'd2;
    localparam logic [1:0] CLS_ABOVE = 2'd3;

    typedef struct packed {
        logic [1:0]         cls;
        logic               esc;
        logic [LEVEL_W-1:0] val;
    } s1_t;

    function automatic s1_t classify(input logic [LEVEL_W-1:0] lvl,
                                     input logic [1:0] base,
                                     input logic [2:0] r);
        s1_t                o;
        logic [LEVEL_W-1:0] sym;
        logic [LEVEL_W-1:0] q;
        sym   = lvl - LEVEL_W'(base);
        q     = sym >> r;
        o.esc = 1'b0;
        o.val = q;
        if (lvl == '0) begin
            o.cls = CLS_ZERO;
        end else if (lvl >= LEVEL_W'(base)) begin
            o.cls = CLS_ABOVE;
            // sym >= (3 << r) is the same test as (sym >> r) >= 3
            if (q >= LEVEL_W'(3)) begin
                o.esc = 1'b1;
                o.val = q - LEVEL_W'(3);
            end
        end else if (lvl == LEVEL_W'(1)) begin
            o.cls = CLS_ONE;
        end else begin
            o.cls = CLS_TWO;
        end
        return o;
    endfunction

    function automatic logic [7:0] esc_unlim(input logic [LEVEL_W-1:0] s_in,
                                             input logic [2:0] r);
        logic [31:0] s;
        logic [31:0] step;
        logic [5:0]  len;
        s   = 32'(s_in);
        len = {3'b000, r};
        for (int i = 0; i < LEVEL_W; i++) begin
            step = 32'd1 << len;
            if (s >= step) begin
                s   = s - step;
                len = len + 6'd1;
            end
        end
        return 8'd4 + 8'(len) + 8'(len) - 8'(r);
    endfunction

    function automatic logic [7:0] esc_limited(input logic [LEVEL_W-1:0] s_in,
                                               input logic [2:0] r,
                                               input logic [4:0] mlog);
        logic [31:0] s;
        logic [5:0]  p;
        logic [5:0]  maxp;
        logic [7:0]  sl;
        s    = 32'(s_in);
        maxp = 6'd29 - {1'b0, mlog};
        p    = '0;
        for (int i = 0; i < LEVEL_W; i++) begin
            if ((p < maxp) && (s > ((32'd2 << p) - 32'd2)))
                p = p + 6'd1;
        end
        sl = (p == maxp) ? (8'(mlog) - 8'(r)) : (8'(p) + 8'd1);
        return 8'd3 + 8'(p) + sl + 8'(r);
    endfunction

    function automatic logic [7:0] code_bits(input s1_t x, input logic [2:0] r,
                                             input logic lim, input logic [4:0] mlog);
        logic [7:0] bits;
        bits = '0;
        if (x.cls == CLS_ABOVE) begin
            if (!x.esc)
                bits = 8'(x.val[1:0]) + 8'd1 + 8'(r);
            else if (lim)
                bits = esc_limited(x.val, r, mlog);
            else
                bits = esc_unlim(x.val, r);
        end
        return bits;
    endfunction

    function automatic logic [16:0] ctx_term(input s1_t x, input logic c1lt8, input logic c2lt1,
                                             input logic [15:0] g0, input logic [15:0] g1,
                                             input logic [15:0] a0, input logic [15:0] a1);
        logic [16:0] t;
        case (x.cls)
            CLS_ONE:   t = 17'(g0);
            CLS_TWO:   t = 17'(g1) + 17'(a0);
            CLS_ABOVE: t = (c1lt8 ? 17'(g1) : 17'd0) + (c2lt1 ? 17'(a1) : 17'd0);
            default:   t = '0;
        endcase
        return t;
    endfunction

    function automatic logic [RATE_W-1:0] sum_rate(input logic nz, input logic [7:0] bits,
                                                   input logic [16:0] ctx);
        logic [WIDE_W-1:0] acc;
        acc = ((WIDE_W'(bits) + WIDE_W'(1)) << FRAC_BITS) + WIDE_W'(ctx);
        if (!nz)
            return '0;
        if (|acc[WIDE_W-1:RATE_W])
            return '1;
        return acc[RATE_W-1:0];
    endfunction

    logic s1_valid;
    logic s2_valid;
    logic adv1;
    logic adv2;
    logic adv3;

    assign adv3     = s2_valid && (!out_valid || out_ready);
    assign adv2     = s1_valid && (!s2_valid || adv3);
    assign in_ready = !s1_valid || adv2;
    assign adv1     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (adv1)
                s1_valid <= 1'b1;
            else if (adv2)
                s1_valid <= 1'b0;
            if (adv2)
                s2_valid <= 1'b1;
            else if (adv3)
                s2_valid <= 1'b0;
            if (adv3)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

    // S1 classify
    logic [1:0] base;
    s1_t        s1_cand_d [NUM_CAND];
    s1_t        s1_cand   [NUM_CAND];
    logic [TAG_W-1:0] s1_tag;
    logic [2:0]       s1_r;
    logic             s1_lim;
    logic [4:0]       s1_mlog;
    logic             s1_c1lt8;
    logic             s1_c2lt1;
    logic [15:0]      s1_g0, s1_g1, s1_a0, s1_a1;

    assign base = (c1_idx < 8'd8) ? ((c2_idx < 8'd1) ? 2'd3 : 2'd2) : 2'd1;

    always_comb begin
        for (int c = 0; c < NUM_CAND; c++)
            s1_cand_d[c] = classify(cand_level[c*LEVEL_W +: LEVEL_W], base, rice_param);
    end

    always_ff @(posedge clk) begin
        if (adv1) begin
            for (int c = 0; c < NUM_CAND; c++)
                s1_cand[c] <= s1_cand_d[c];
            s1_tag   <= in_tag;
            s1_r     <= rice_param;
            s1_lim   <= use_limited_prefix;
            s1_mlog  <= max_log2_tr_range;
            s1_c1lt8 <= (c1_idx < 8'd8);
            s1_c2lt1 <= (c2_idx < 8'd1);
            s1_g0    <= gt1_cost0;
            s1_g1    <= gt1_cost1;
            s1_a0    <= abs_cost0;
            s1_a1    <= abs_cost1;
        end
    end

    // S2 code
    logic [7:0]  s2_bits_d [NUM_CAND];
    logic [16:0] s2_ctx_d  [NUM_CAND];
    logic        s2_nz_d   [NUM_CAND];
    logic [7:0]  s2_bits   [NUM_CAND];
    logic [16:0] s2_ctx    [NUM_CAND];
    logic        s2_nz     [NUM_CAND];
    logic [TAG_W-1:0] s2_tag;

    always_comb begin
        for (int c = 0; c < NUM_CAND; c++) begin
            s2_bits_d[c] = code_bits(s1_cand[c], s1_r, s1_lim, s1_mlog);
            s2_ctx_d[c]  = ctx_term(s1_cand[c], s1_c1lt8, s1_c2lt1, s1_g0, s1_g1, s1_a0, s1_a1);
            s2_nz_d[c]   = (s1_cand[c].cls != CLS_ZERO);
        end
    end

    always_ff @(posedge clk) begin
        if (adv2) begin
            for (int c = 0; c < NUM_CAND; c++) begin
                s2_bits[c] <= s2_bits_d[c];
                s2_ctx[c]  <= s2_ctx_d[c];
                s2_nz[c]   <= s2_nz_d[c];
            end
            s2_tag <= s1_tag;
        end
    end

    // S3 sum
    logic [NUM_CAND*RATE_W-1:0] rate_d;

    always_comb begin
        rate_d = '0;
        for (int c = 0; c < NUM_CAND; c++)
            rate_d[c*RATE_W +: RATE_W] = sum_rate(s2_nz[c], s2_bits[c], s2_ctx[c]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_tag  <= '0;
            out_rate <= '0;
        end else if (adv3) begin
            out_tag  <= s2_tag;
            out_rate <= rate_d;
        end
    end

`ifdef CABAC_RATE_PERF_EN
    logic [31:0] esc_inc;

    always_comb begin
        esc_inc = '0;
        for (int c = 0; c < NUM_CAND; c++)
            esc_inc = esc_inc + 32'(s1_cand_d[c].esc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_req_cnt    <= '0;
            perf_stall_cnt  <= '0;
            perf_escape_cnt <= '0;
        end else begin
            if (adv1) begin
                perf_req_cnt    <= perf_req_cnt + 32'd1;
                perf_escape_cnt <= perf_escape_cnt + esc_inc;
            end
            if (out_valid && !out_ready)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cabac_rate_est_pipe.sv
// Self-checking bench for cabac_rate_est_pipe: directed cases, a stalled random stream and reset flush.
// Perf counter checks are included when CABAC_RATE_PERF_EN is defined.
module tb_cabac_rate_est_pipe;
    localparam int NC = 3;
    localparam int LW = 16;
    localparam int RW = 32;
    localparam int FB = 15;
    localparam int TW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [TW-1:0]     in_tag;
    logic [NC*LW-1:0]  cand_level;
    logic [7:0]        c1_idx;
    logic [7:0]        c2_idx;
    logic [15:0]       gt1_cost0, gt1_cost1, abs_cost0, abs_cost1;
    logic [2:0]        rice_param;
    logic              use_limited_prefix;
    logic [4:0]        max_log2_tr_range;
    logic              out_valid;
    logic              out_ready;
    logic [TW-1:0]     out_tag;
    logic [NC*RW-1:0]  out_rate;
`ifdef CABAC_RATE_PERF_EN
    logic [31:0]       perf_req_cnt, perf_stall_cnt, perf_escape_cnt;
    int                esc_model;
`endif

    always #5 clk = ~clk;

    cabac_rate_est_pipe #(
        .NUM_CAND(NC), .LEVEL_W(LW), .RATE_W(RW), .FRAC_BITS(FB), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .cand_level(cand_level), .c1_idx(c1_idx), .c2_idx(c2_idx),
        .gt1_cost0(gt1_cost0), .gt1_cost1(gt1_cost1),
        .abs_cost0(abs_cost0), .abs_cost1(abs_cost1),
        .rice_param(rice_param), .use_limited_prefix(use_limited_prefix),
        .max_log2_tr_range(max_log2_tr_range),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_rate(out_rate)
`ifdef CABAC_RATE_PERF_EN
        , .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt),
        .perf_escape_cnt(perf_escape_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Rate of one candidate, straight from the coding rules in integer arithmetic.
    function automatic longint unsigned ref_rate(int l, int c1, int c2, int g0, int g1,
                                                 int a0, int a1, int r, bit lim, int mlog);
        longint unsigned rate;
        int base, sym, bits, len, s, p, maxp, sl;
        if (l == 0) return 0;
        base = (c1 < 8) ? ((c2 < 1) ? 3 : 2) : 1;
        rate = longint'(1) << FB;
        if (l >= base) begin
            sym = l - base;
            if (sym < (3 << r)) begin
                bits = (sym >> r) + 1 + r;
            end else if (!lim) begin
                len = r;
                s = (sym >> r) - 3;
                while (s >= (1 << len)) begin
                    s -= (1 << len);
                    len++;
                end
                bits = 3 + len + 1 - r + len;
            end else begin
                maxp = 32 - (3 + mlog);
                p = 0;
                s = (sym >> r) - 3;
                while (p < maxp && s > (2 << p) - 2) p++;
                sl = (p == maxp) ? mlog - r : p + 1;
                bits = 3 + p + sl + r;
            end
            rate += longint'(bits) << FB;
            if (c1 < 8) rate += longint'(g1);
            if (c2 < 1) rate += longint'(a1);
        end else if (l == 1) begin
            rate += longint'(g0);
        end else begin
            rate += longint'(g1) + longint'(a0);
        end
        if (rate > 64'hFFFF_FFFF) rate = 64'hFFFF_FFFF;
        return rate;
    endfunction

    function automatic logic [NC*RW-1:0] ref_vec();
        logic [NC*RW-1:0] v;
        for (int c = 0; c < NC; c++)
            v[c*RW +: RW] = 32'(ref_rate(int'(cand_level[c*LW +: LW]), int'(c1_idx), int'(c2_idx),
                                         int'(gt1_cost0), int'(gt1_cost1), int'(abs_cost0),
                                         int'(abs_cost1), int'(rice_param), use_limited_prefix,
                                         int'(max_log2_tr_range)));
        return v;
    endfunction

`ifdef CABAC_RATE_PERF_EN
    function automatic int esc_count();
        int n, l, base;
        n = 0;
        base = (c1_idx < 8) ? ((c2_idx < 1) ? 3 : 2) : 1;
        for (int c = 0; c < NC; c++) begin
            l = int'(cand_level[c*LW +: LW]);
            if (l > 0 && l >= base && (l - base) >= (3 << rice_param)) n++;
        end
        return n;
    endfunction
`endif

    task automatic rand_inputs();
        for (int c = 0; c < NC; c++) begin
            int sel;
            logic [15:0] v;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       v = 16'($urandom_range(0, 4));
                1:       v = 16'($urandom_range(0, 80));
                2:       v = 16'($urandom_range(0, 1200));
                default: v = 16'($urandom);
            endcase
            cand_level[c*LW +: LW] = v;
        end
        c1_idx             = 8'($urandom_range(0, 10));
        c2_idx             = 8'($urandom_range(0, 2));
        gt1_cost0          = 16'($urandom);
        gt1_cost1          = 16'($urandom);
        abs_cost0          = 16'($urandom);
        abs_cost1          = 16'($urandom);
        rice_param         = 3'($urandom_range(0, 4));
        use_limited_prefix = 1'($urandom_range(0, 1));
        max_log2_tr_range  = 5'($urandom_range(15, 22));
    endtask

    // Issues one request with the currently driven inputs and checks latency, tag and rates.
    task automatic run_single(input string name, input logic [TW-1:0] tag,
                              input logic [NC*RW-1:0] exp_rate);
        logic [NC*RW-1:0] mv;
        int lat;
        in_tag   = tag;
        in_valid = 1'b1;
        #1;
        chk({name, "_in_ready"}, in_ready, 1'b1);
        mv = ref_vec();
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, lat, 3);
        chk({name, "_tag"}, out_tag, tag);
        chk({name, "_rate"}, out_rate, exp_rate);
        chk({name, "_rate_model"}, out_rate, mv);
        step();
    endtask

    logic [TW+NC*RW-1:0] exp_q[$];
    logic [TW+NC*RW-1:0] e;
    logic [NC*RW-1:0]    prev_rate;
    logic [TW-1:0]       prev_tag;
    logic                prev_hold;
    int sent, got, cyc, first_block, seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_tag = '0; cand_level = '0;
        c1_idx = '0; c2_idx = '0; gt1_cost0 = '0; gt1_cost1 = '0; abs_cost0 = '0; abs_cost1 = '0;
        rice_param = '0; use_limited_prefix = 1'b0; max_log2_tr_range = 5'd15;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_rate", out_rate, '0);
        chk("rst_out_tag", out_tag, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        step();

        // base 3 case with all context terms
        c1_idx = 8'd0; c2_idx = 8'd0;
        gt1_cost0 = 16'h1000; gt1_cost1 = 16'h2000; abs_cost0 = 16'h0800; abs_cost1 = 16'h2500;
        rice_param = 3'd0; use_limited_prefix = 1'b0; max_log2_tr_range = 5'd15;
        cand_level = {16'd3, 16'd2, 16'd1};
        run_single("dir_base3", 8'h11, {32'h0001_4500, 32'h0000_A800, 32'h0000_9000});

        // base 1, unlimited-prefix escape
        c1_idx = 8'd8; c2_idx = 8'd1; rice_param = 3'd1;
        cand_level = {16'd10, 16'd1, 16'd0};
        run_single("dir_unlim", 8'h22, {32'h0003_0000, 32'h0001_8000, 32'h0000_0000});

        // same with limited-prefix escape
        use_limited_prefix = 1'b1; max_log2_tr_range = 5'd15;
        run_single("dir_limited", 8'h33, {32'h0004_0000, 32'h0001_8000, 32'h0000_0000});

        // escape threshold at R=4: sym 47 stays regular, sym 48 escapes; plus max level
        c1_idx = 8'd9; c2_idx = 8'd5; rice_param = 3'd4; use_limited_prefix = 1'b0;
        cand_level = {16'hFFFF, 16'd49, 16'd48};
        run_single("dir_thresh", 8'h44, {32'h000C_8000, 32'h0004_8000, 32'h0004_0000});

        // stalled random stream
        rst = 1'b1;
        step();
        rst = 1'b0;
        sent = 0; got = 0; cyc = 0; first_block = -1; prev_hold = 1'b0;
        prev_rate = '0; prev_tag = '0;
`ifdef CABAC_RATE_PERF_EN
        esc_model = 0;
`endif
        while (got < 16 && cyc < 200) begin
            out_ready = !(cyc >= 6 && cyc < 11);
            if (sent < 16) begin
                rand_inputs();
                in_tag   = 8'(8'h40 + sent);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_hold) begin
                chk("stall_rate_hold", out_rate, prev_rate);
                chk("stall_tag_hold", out_tag, prev_tag);
            end
            if (cyc >= 6 && cyc < 11 && !in_ready && first_block < 0)
                first_block = cyc;
            if (out_valid && out_ready) begin
                chk("stream_not_extra", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("stream_tag", out_tag, e[TW+NC*RW-1 -: TW]);
                    chk("stream_rate", out_rate, e[NC*RW-1:0]);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({in_tag, ref_vec()});
`ifdef CABAC_RATE_PERF_EN
                esc_model += esc_count();
`endif
                sent++;
            end
            prev_hold = out_valid && !out_ready;
            prev_rate = out_rate;
            prev_tag  = out_tag;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", got, 16);
        chk("stream_queue_empty", exp_q.size(), 0);
        chk("stream_in_ready_fell", (first_block >= 6) && (first_block <= 8), 1'b1);
`ifdef CABAC_RATE_PERF_EN
        chk("perf_req_cnt", perf_req_cnt, 32'd16);
        chk("perf_stall_cnt", perf_stall_cnt, 32'd5);
        chk("perf_escape_cnt", perf_escape_cnt, 32'(esc_model));
`endif
        step();

        // reset with two requests in flight
        rand_inputs();
        in_tag = 8'hA0; in_valid = 1'b1;
        step();
        rand_inputs();
        in_tag = 8'hA1;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("flush_no_emit", seen, 0);
        rand_inputs();
        run_single("post_flush", 8'hB5, ref_vec());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
